fast_divider_nr: RTL and testbench

Parametrised Newton-Raphson unsigned integer divider, the multi-width successor to the 4-bit fast divider. It normalises the divisor, refines a reciprocal estimate over a fixed number of iterations, forms a quotient estimate, and corrects it to an exact quotient and remainder. It has a start/busy/done handshake, divide-by-zero reporting and fixed latency, and sits as a multi-cycle execute unit beside the slow (restoring) divider in the arithmetic datapath.

---
 rtl/fast_div_pkg.sv | 32 +++
 rtl/fast_div_lzc.sv | 18 +
 rtl/fast_divider_nr.sv | 207 ++++++++++++++++++++
 tb/tb_fast_divider_nr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fast_div_pkg.sv
// Shared types and elaboration-time helpers for the Newton-Raphson divider.
package fast_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    SEED,
    ITER_A,
    ITER_B,
    QEST,
    CORR,
    DONE
  } state_e;

  // Seed line X0 = 48/17 - 32/17*d, constants rounded to 'frac' fraction bits.
  function automatic logic [63:0] seed_c48(input int unsigned frac);
    return ((64'd48 << frac) + 64'd8) / 64'd17;
  endfunction

  function automatic logic [63:0] seed_c32(input int unsigned frac);
    return ((64'd32 << frac) + 64'd8) / 64'd17;
  endfunction

  // Smallest k with 4 * 2^k >= width + 1, i.e. ceil(log2((width+1)/4)).
  function automatic int unsigned min_iter(input int unsigned width);
    int unsigned k;
    k = 0;
    while ((32'd4 << k) < (width + 32'd1)) k = k + 1;
    return k;
  endfunction

endpackage

// File: rtl/fast_div_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fast_div_lzc #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LZW = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [LZW-1:0]   count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = LZW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value_i[i]) count_o = LZW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fast_divider_nr.sv
// Newton-Raphson unsigned divider: normalise, seed, refine reciprocal, estimate, correct.
module fast_divider_nr
  import fast_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITER  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned FRAC = 2 * WIDTH;
  localparam int unsigned XW   = FRAC + 2;
  localparam int unsigned PW   = WIDTH + FRAC + 2;
  localparam int unsigned MW   = 2 * FRAC + 4;
  localparam int unsigned RW   = 2 * WIDTH + 1;
  localparam int unsigned LZW  = $clog2(WIDTH) + 1;
  localparam int unsigned IW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [XW-1:0] C48 = XW'(seed_c48(FRAC));
  localparam logic [XW-1:0] C32 = XW'(seed_c32(FRAC));
  localparam logic [XW-1:0] TWO = XW'(2) << FRAC;

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("fast_divider_nr: WIDTH must be within 4..16");
  end
  if (ITER < min_iter(WIDTH)) begin : g_bad_iter
    $error("fast_divider_nr: ITER too small for WIDTH");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dn_q, dn_d, q_q, q_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [LZW-1:0]   lz_q, lz_d, lz_c;
  logic [XW-1:0]    x_q, x_d, t_q, t_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             corr_q, corr_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [XW-1:0]         seed_prod, dx, xt;
  logic [7:0]            qshift;
  logic [WIDTH-1:0]      q_est, q_fix, rem_fix;
  logic signed [RW-1:0]  r_c, b_s;

  fast_div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .value_i (b_q),
    .count_o (lz_c)
  );

  // One wide product per state; each is a plain truncation of the fixed-point result.
  always_comb begin
    seed_prod = XW'((PW'(C32) * PW'(dn_q)) >> WIDTH);
    dx        = XW'((PW'(dn_q) * PW'(x_q)) >> WIDTH);
    xt        = XW'((MW'(x_q) * MW'(t_q)) >> FRAC);
    qshift    = 8'(FRAC + WIDTH) - 8'(lz_q);
    q_est     = WIDTH'((PW'(a_q) * PW'(x_q)) >> qshift);
    b_s       = $signed(RW'(b_q));
    r_c       = $signed(RW'(a_q)) - $signed(RW'(q_q) * RW'(b_q));
    if (r_c < 0) begin
      q_fix   = q_q - WIDTH'(1);
      rem_fix = WIDTH'(r_c + b_s);
    end else if (r_c >= b_s) begin
      q_fix   = q_q + WIDTH'(1);
      rem_fix = WIDTH'(r_c - b_s);
    end else begin
      q_fix   = q_q;
      rem_fix = WIDTH'(r_c);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dn_d    = dn_q;
    lz_d    = lz_q;
    x_d     = x_q;
    t_d     = t_q;
    iter_d  = iter_q;
    q_d     = q_q;
    corr_d  = corr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = dividend;
          b_d    = divisor;
          busy_d = 1'b1;
          corr_d = 1'b0;
          // Zero divisor reuses the two CORR cycles as a delay so done lands on edge 2.
          if (divisor == '0) begin
            zero_d  = 1'b1;
            state_d = CORR;
          end else begin
            zero_d  = 1'b0;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        lz_d    = lz_c;
        dn_d    = WIDTH'(b_q << lz_c);
        state_d = SEED;
      end
      SEED: begin
        x_d     = C48 - seed_prod;
        iter_d  = '0;
        state_d = ITER_A;
      end
      ITER_A: begin
        t_d     = (dx > TWO) ? '0 : TWO - dx;
        state_d = ITER_B;
      end
      ITER_B: begin
        x_d = xt;
        if (iter_q == IW'(ITER - 1)) begin
          state_d = QEST;
        end else begin
          iter_d  = iter_q + IW'(1);
          state_d = ITER_A;
        end
      end
      QEST: begin
        q_d     = q_est;
        corr_d  = 1'b0;
        state_d = CORR;
      end
      CORR: begin
        if (!zero_q) q_d = q_fix;
        if (!corr_q) begin
          corr_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dbz_d   = zero_q;
          quot_d  = zero_q ? '1 : q_fix;
          rem_d   = zero_q ? a_q : rem_fix;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dn_q    <= '0;
      lz_q    <= '0;
      x_q     <= '0;
      t_q     <= '0;
      iter_q  <= '0;
      q_q     <= '0;
      corr_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dn_q    <= dn_d;
      lz_q    <= lz_d;
      x_q     <= x_d;
      t_q     <= t_d;
      iter_q  <= iter_d;
      q_q     <= q_d;
      corr_q  <= corr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_fast_divider_nr.sv
// Bench for fast_divider_nr at WIDTH 8, 4 and 16 against a plain '/' and '%' model.
module tb_fast_divider_nr;

  localparam int ITERS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8 = 1'b0, s4 = 1'b0, s16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic [3:0]  a4 = '0, b4 = '0, q4, r4;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic        busy8, done8, z8, busy4, done4, z4, busy16, done16, z16;

  fast_divider_nr #(.WIDTH(8), .ITER(ITERS)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .dbz(z8));

  fast_divider_nr #(.WIDTH(4), .ITER(ITERS)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .dbz(z4));

  fast_divider_nr #(.WIDTH(16), .ITER(ITERS)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .dbz(z16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned a, b, q, r;
    bit          z;
    int          lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int u, input bit s, input int unsigned a, input int unsigned b);
    case (u)
      0: begin s8 = s; a8 = 8'(a); b8 = 8'(b); end
      1: begin s4 = s; a4 = 4'(a); b4 = 4'(b); end
      default: begin s16 = s; a16 = 16'(a); b16 = 16'(b); end
    endcase
  endtask

  function automatic bit get_busy(input int u);
    return (u == 0) ? busy8 : (u == 1) ? busy4 : busy16;
  endfunction
  function automatic bit get_done(input int u);
    return (u == 0) ? done8 : (u == 1) ? done4 : done16;
  endfunction
  function automatic bit get_z(input int u);
    return (u == 0) ? z8 : (u == 1) ? z4 : z16;
  endfunction
  function automatic int unsigned get_q(input int u);
    return (u == 0) ? 32'(q8) : (u == 1) ? 32'(q4) : 32'(q16);
  endfunction
  function automatic int unsigned get_r(input int u);
    return (u == 0) ? 32'(r8) : (u == 1) ? 32'(r4) : 32'(r16);
  endfunction

  task automatic do_op(input int u, input int unsigned a, input int unsigned b,
                       output int unsigned q, output int unsigned r, output bit z, output int lat);
    @(negedge clk);
    drive(u, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive(u, 1'b0, a, b);
    check($sformatf("u%0d busy after accept", u), get_busy(u), 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (get_done(u)) begin
        lat = c;
        break;
      end
    end
    q = get_q(u);
    r = get_r(u);
    z = get_z(u);
    check($sformatf("u%0d busy low with done", u), get_busy(u), 0);
    @(posedge clk);
    #1;
    check($sformatf("u%0d done single pulse", u), get_done(u), 0);
  endtask

  task automatic run_check(input int u, input int unsigned a, input int unsigned b);
    int unsigned w, mask, eq, er, q, r;
    bit ez, z;
    int elat, lat;
    w    = (u == 0) ? 8 : (u == 1) ? 4 : 16;
    mask = (32'd1 << w) - 1;
    ez   = (b == 0);
    eq   = ez ? mask : a / b;
    er   = ez ? a : a % b;
    elat = ez ? 2 : 5 + 2 * ITERS;
    do_op(u, a, b, q, r, z, lat);
    check($sformatf("u%0d %0d/%0d quotient", u, a, b), q, eq);
    check($sformatf("u%0d %0d/%0d remainder", u, a, b), r, er);
    check($sformatf("u%0d %0d/%0d dbz", u, a, b), z, ez);
    check($sformatf("u%0d %0d/%0d latency", u, a, b), lat, elat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   lat;

    vecs[0] = '{13, 4, 3, 1, 1'b0, 11};
    vecs[1] = '{255, 1, 255, 0, 1'b0, 11};
    vecs[2] = '{1, 255, 0, 1, 1'b0, 11};
    vecs[3] = '{200, 200, 1, 0, 1'b0, 11};
    vecs[4] = '{77, 0, 255, 77, 1'b1, 2};
    vecs[5] = '{10, 3, 3, 1, 1'b0, 11};
    vecs[6] = '{0, 5, 0, 0, 1'b0, 11};
    vecs[7] = '{254, 127, 2, 0, 1'b0, 11};
    vecs[8] = '{128, 3, 42, 2, 1'b0, 11};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs u8", {busy8, done8, z8, q8, r8}, 0);
    check("reset outputs u4", {busy4, done4, z4, q4, r4}, 0);
    check("reset outputs u16", {busy16, done16, z16, q16, r16}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      int unsigned q, r;
      bit z;
      do_op(0, vecs[i].a, vecs[i].b, q, r, z, lat);
      check($sformatf("vec%0d quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d dbz", i), z, vecs[i].z);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // start held high and operands churning while busy, then through the done cycle
    @(negedge clk);
    drive(0, 1'b1, 100, 7);
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      drive(0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (done8) begin
        lat = c;
        break;
      end
    end
    check("busy-start quotient", q8, 14);
    check("busy-start remainder", r8, 2);
    check("busy-start latency", lat, 11);
    @(posedge clk);
    #1;
    check("start in done cycle ignored", busy8, 0);
    drive(0, 1'b0, 0, 0);
    @(posedge clk);
    #1;

    // asynchronous abort mid-operation
    @(negedge clk);
    drive(0, 1'b1, 100, 7);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 100, 7);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy8, 0);
    check("abort quotient", q8, 0);
    check("abort remainder", r8, 0);
    check("abort done/dbz", {done8, z8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check(0, 100, 7);
    run_check(0, 10, 3);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_check(1, a, b);

    run_check(2, 16'hFFFF, 1);
    run_check(2, 16'hFFFF, 16'h8000);
    run_check(2, 16'hFFFF, 16'hFFFF);
    run_check(2, 16'h7FFF, 16'h8000);
    run_check(2, 16'h1234, 0);
    for (int i = 0; i < 20; i++) begin
      run_check(2, $urandom_range(0, 65535), 1);
      run_check(2, $urandom_range(0, 65535), 16'h8000);
      run_check(2, $urandom_range(0, 65535), 16'hFFFF);
    end
    for (int i = 0; i < 3000; i++)
      run_check(2, $urandom_range(0, 65535), $urandom_range(0, 65535));

    for (int i = 0; i < 300; i++)
      run_check(0, $urandom_range(0, 255), $urandom_range(0, 255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
